bcd_serial_adder: RTL and testbench
===================================

Name: bcd_serial_adder

Overview:
- Parametrised multi-digit BCD adder/subtractor. It generalises the 4-bit single-digit BCD adder to DIGITS digits and adds a ten's-complement subtract mode and invalid-digit detection.
- It processes one digit per clock, least-significant digit first, using a single shared digit-correction stage.
- It uses valid/ready handshakes on input and output, so it drops into streaming datapaths such as counters, display drivers and decimal accumulators.

Parameters:
- DIGITS, 4, number of BCD digits per operand (>=1); operand width is 4*DIGITS.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands and mode present
- in_ready  output  1  block can accept operands
- sub  input  1  0 = a+b, 1 = a-b; sampled with in_valid
- a  input  4*DIGITS  BCD operand A, digit 0 in [3:0]
- b  input  4*DIGITS  BCD operand B
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- sum  output  4*DIGITS  BCD result
- carry  output  1  add: decimal carry-out; sub: 1 = no borrow (a>=b)
- err  output  1  an input digit was >9

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset (rst_n low, any state, including mid-operation):
  - state=IDLE.
  - in_ready=0, out_valid=0, sum=0, carry=0, err=0.
  - Internal operand, carry and digit counter registers cleared.
  - in_ready rises on the first clk edge after rst_n deasserts.
- All outputs are registered.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready, capture:
    - A;
    - B, or nines-complement of each B digit (9-d, truncated to 4 bits) when sub=1;
    - initial carry c = sub;
    - cnt = 0;
    - err flag = any digit of a or b > 9.
  - Then go to RUN with in_ready=0.
- RUN, one digit per cycle on digit cnt:
  - raw = a_d + b_d + c (5-bit).
  - If raw > 9: digit = (raw + 6)[3:0], c = 1.
  - Else: digit = raw[3:0], c = 0.
  - Write digit into result position cnt; cnt++.
  - After the digit DIGITS-1 cycle, go to DONE.
- DONE:
  - out_valid=1.
  - sum = result and carry = c, unless err is set; then sum=0, carry=0, err=1.
  - sum, carry and err are held stable while out_ready=0.
  - On out_valid && out_ready, go to IDLE: out_valid=0 and in_ready=1 from the next cycle.
- Latency: out_valid rises DIGITS clk edges after the accepting edge.
  - Throughput: one operation per DIGITS+2 cycles when out_ready=1.
- Subtract result:
  - a>=b: sum = a-b, carry=1.
  - a<b: sum = 10^DIGITS + a - b (ten's complement), carry=0.
- in_valid is ignored outside IDLE. Inputs a, b and sub may change freely after acceptance.
- err and sum/carry are cleared when the next operation is accepted.
- DIGITS=1 must work: a single RUN cycle.

Test Plan:
- Run all scenarios with DIGITS=4.
- Reset, then add 0x0000+0x0000 -> in_ready=1 one edge after reset release; out_valid exactly 4 edges after accept; sum=0x0000, carry=0, err=0.
- Add 0x1234+0x5678 -> sum=0x6912, carry=0. Add 0x9999+0x0001 -> sum=0x0000, carry=1 (carry ripples through every digit).
- Sub 0x5000-0x1234 -> sum=0x3766, carry=1. Sub 0x1234-0x5000 -> sum=0x6234, carry=0. Sub 0x0042-0x0042 -> sum=0x0000, carry=1.
- Invalid digit: add a=0x12A4, b=0x0001 -> err=1, sum=0x0000, carry=0, same latency. A following valid add 0x0001+0x0001 -> err=0, sum=0x0002.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid, sum and carry stable; in_ready=0; in_valid pulses ignored. Raise out_ready -> handshake completes; in_ready=1 the next cycle.
- Reset mid-RUN: assert rst_n low asynchronously (between clk edges) during the second digit -> all outputs 0 immediately. After release, a new add 0x0005+0x0005 -> sum=0x0010, carry=0.

Source files
------------

// File: rtl/bcd_serial_adder_if.sv
// Handshake bundle for the serial BCD adder/subtractor: operand side and result side.
// The master drives operands and result acceptance; the slave (the adder) answers.
interface bcd_serial_adder_if #(
  parameter int DIGITS = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic                  sub;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   sum;
  logic                  carry;
  logic                  err;

  modport master (
    output in_valid, sub, a, b, out_ready,
    input  in_ready, out_valid, sum, carry, err
  );

  modport slave (
    input  in_valid, sub, a, b, out_ready,
    output in_ready, out_valid, sum, carry, err
  );
endinterface

// File: rtl/bcd_serial_adder.sv
// Multi-digit BCD adder/subtractor, one digit per clock LSD first through a single
// shared decimal-correction stage; subtraction is ten's complement (nines + carry-in).
module bcd_serial_adder #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  bcd_serial_adder_if.slave   bus
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic has_bad_digit(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      bad = bad | (v[4*i +: 4] > 4'd9);
    end
    return bad;
  endfunction

  function automatic logic [W-1:0] nines(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = {W{1'b0}};
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'd9 - v[4*i +: 4];
    end
    return r;
  endfunction

  // Returns {carry_out, corrected_digit}.
  function automatic logic [4:0] digit_add(input logic [3:0] x, input logic [3:0] y,
                                           input logic cin);
    logic [4:0] raw;
    raw = {1'b0, x} + {1'b0, y} + {4'b0000, cin};
    if (raw > 5'd9) begin
      return {1'b1, raw[3:0] + 4'd6};
    end else begin
      return {1'b0, raw[3:0]};
    end
  endfunction

  state_t        state_r;
  logic [W-1:0]  a_r;
  logic [W-1:0]  b_r;
  logic [W-1:0]  res_r;
  logic          c_r;
  logic [CW-1:0] cnt_r;
  logic          err_r;
  logic          in_ready_r;
  logic          out_valid_r;
  logic [W-1:0]  sum_r;
  logic          carry_r;
  logic          err_out_r;

  logic [4:0]    step_s;
  logic [W-1:0]  digit_ext_s;
  logic [W-1:0]  res_next_s;

  // Current digit step; operands shift right so digit 0 is always at [3:0].
  always_comb begin
    step_s      = digit_add(a_r[3:0], b_r[3:0], c_r);
    digit_ext_s = {W{1'b0}};
    digit_ext_s[W-1 -: 4] = step_s[3:0];
    res_next_s  = (res_r >> 4'd4) | digit_ext_s;
  end

  // Control FSM with datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      a_r         <= {W{1'b0}};
      b_r         <= {W{1'b0}};
      res_r       <= {W{1'b0}};
      c_r         <= 1'b0;
      cnt_r       <= {CW{1'b0}};
      err_r       <= 1'b0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      sum_r       <= {W{1'b0}};
      carry_r     <= 1'b0;
      err_out_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid && in_ready_r) begin
            a_r        <= bus.a;
            b_r        <= bus.sub ? nines(bus.b) : bus.b;
            c_r        <= bus.sub;
            cnt_r      <= {CW{1'b0}};
            err_r      <= has_bad_digit(bus.a) | has_bad_digit(bus.b);
            res_r      <= {W{1'b0}};
            sum_r      <= {W{1'b0}};
            carry_r    <= 1'b0;
            err_out_r  <= 1'b0;
            in_ready_r <= 1'b0;
            state_r    <= RUN;
          end else begin
            in_ready_r <= 1'b1;
          end
        end
        RUN: begin
          a_r   <= a_r >> 4'd4;
          b_r   <= b_r >> 4'd4;
          c_r   <= step_s[4];
          res_r <= res_next_s;
          if (cnt_r == LAST) begin
            state_r     <= DONE;
            out_valid_r <= 1'b1;
            // An invalid input digit suppresses the arithmetic result entirely.
            if (err_r) begin
              sum_r     <= {W{1'b0}};
              carry_r   <= 1'b0;
              err_out_r <= 1'b1;
            end else begin
              sum_r     <= res_next_s;
              carry_r   <= step_s[4];
              err_out_r <= 1'b0;
            end
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end else begin
            out_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b0;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.sum       = sum_r;
  assign bus.carry     = carry_r;
  assign bus.err       = err_out_r;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Directed bench for bcd_serial_adder (DIGITS=4): add, subtract, invalid digits,
// backpressure and asynchronous reset during RUN.
module tb_bcd_serial_adder;

  localparam int DIGITS = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  bcd_serial_adder_if #(.DIGITS(DIGITS)) bus ();

  bcd_serial_adder #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input string tag, input logic s, input logic [15:0] av,
                        input logic [15:0] bv);
    check({tag, "_ready"}, bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.sub      = s;
    bus.a        = av;
    bus.b        = bv;
    tick();
    // Inputs may change freely once accepted.
    bus.in_valid = 1'b0;
    bus.sub      = ~s;
    bus.a        = 16'h9999;
    bus.b        = 16'h9999;
    check({tag, "_busy"}, bus.in_ready, 0);
  endtask

  task automatic await_result(input string tag, input logic [15:0] es, input logic ec,
                              input logic ee);
    int lat;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bus.out_valid === 1'b1) begin
        lat = i;
        break;
      end
    end
    check({tag, "_lat"}, lat, 4);
    check({tag, "_sum"}, bus.sum, es);
    check({tag, "_carry"}, bus.carry, ec);
    check({tag, "_err"}, bus.err, ee);
  endtask

  task automatic complete(input string tag);
    bus.out_ready = 1'b1;
    tick();
    check({tag, "_ovdrop"}, bus.out_valid, 0);
    check({tag, "_rdy"}, bus.in_ready, 1);
  endtask

  task automatic op(input string tag, input logic s, input logic [15:0] av,
                    input logic [15:0] bv, input logic [15:0] es, input logic ec,
                    input logic ee);
    accept(tag, s, av, bv);
    await_result(tag, es, ec, ee);
    complete(tag);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.sub       = 1'b0;
    bus.a         = 16'h0000;
    bus.b         = 16'h0000;
    bus.out_ready = 1'b1;

    repeat (3) tick();
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_sum", bus.sum, 0);
    check("rst_carry", bus.carry, 0);
    check("rst_err", bus.err, 0);
    rst_n = 1'b1;
    check("rel_in_ready_low", bus.in_ready, 0);
    tick();
    check("rel_in_ready_high", bus.in_ready, 1);

    op("add0", 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    op("add1", 1'b0, 16'h1234, 16'h5678, 16'h6912, 1'b0, 1'b0);
    op("add_ripple", 1'b0, 16'h9999, 16'h0001, 16'h0000, 1'b1, 1'b0);
    op("sub_ge", 1'b1, 16'h5000, 16'h1234, 16'h3766, 1'b1, 1'b0);
    op("sub_lt", 1'b1, 16'h1234, 16'h5000, 16'h6234, 1'b0, 1'b0);
    op("sub_eq", 1'b1, 16'h0042, 16'h0042, 16'h0000, 1'b1, 1'b0);
    op("bad_digit", 1'b0, 16'h12A4, 16'h0001, 16'h0000, 1'b0, 1'b1);
    op("after_bad", 1'b0, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0);

    // Backpressure: result held while out_ready is low, in_valid pulses ignored.
    bus.out_ready = 1'b0;
    accept("bp", 1'b0, 16'h1234, 16'h5678);
    await_result("bp", 16'h6912, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      bus.in_valid = 1'b1;
      bus.a        = 16'h1111;
      bus.b        = 16'h2222;
      tick();
      check("bp_hold_valid", bus.out_valid, 1);
      check("bp_hold_sum", bus.sum, 16'h6912);
      check("bp_hold_carry", bus.carry, 0);
      check("bp_hold_ready", bus.in_ready, 0);
    end
    bus.in_valid = 1'b0;
    complete("bp");
    op("post_bp", 1'b0, 16'h0999, 16'h0001, 16'h1000, 1'b0, 1'b0);

    // Asynchronous reset while the second digit is being processed.
    accept("mid", 1'b0, 16'h9999, 16'h9999);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_in_ready", bus.in_ready, 0);
    check("mid_out_valid", bus.out_valid, 0);
    check("mid_sum", bus.sum, 0);
    check("mid_carry", bus.carry, 0);
    check("mid_err", bus.err, 0);
    tick();
    tick();
    rst_n = 1'b1;
    check("mid_rel_low", bus.in_ready, 0);
    tick();
    check("mid_rel_high", bus.in_ready, 1);
    op("after_rst", 1'b0, 16'h0005, 16'h0005, 16'h0010, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
